ls_apb_ctrl: RTL and testbench
==============================

LS_APB_CTRL -- requirements
Module: ls_apb_ctrl

Interface
REQ-001 Parameter Amba_Addr_Depth, default 20, APB address width.
REQ-002 Parameter Amba_Word, default 16, APB data width and frame counter width.
REQ-003 Parameter PixelPrecision, default 8, pixel and threshold width.
REQ-004 Port clk, in, 1, the single clock; all logic is on the rising edge.
REQ-005 Port rst, in, 1, synchronous active-high reset.
REQ-006 Port PADDR, in, Amba_Addr_Depth, APB word address.
REQ-007 Ports PSEL, PENABLE, PWRITE, in, 1 each, APB control with zero wait states and no PREADY.
REQ-008 Port PWDATA, in, Amba_Word, APB write data.
REQ-009 Port PRDATA, out, Amba_Word, APB read data.
REQ-010 Port cfg_width, out, Amba_Word, image width in pixels.
REQ-011 Port cfg_height, out, Amba_Word, image height in pixels.
REQ-012 Port cfg_thresh, out, PixelPrecision, separation threshold.
REQ-013 Port pix_en, out, 1, separator pixel strobe; ImInput is consumed on each cycle it is high.
REQ-014 Port pix_col, out, Amba_Word, column of the current pixel.
REQ-015 Port pix_row, out, Amba_Word, row of the current pixel.
REQ-016 Port frame_done, out, 1, one-cycle pulse after the last pixel.

Function
REQ-017 Register map (word address):
- 0 CTRL, write-only: bit0 START, bit1 ABORT; both self-clearing; reads return 0.
- 1 WIDTH, RW.
- 2 HEIGHT, RW.
- 3 THRESH, RW, bits [PixelPrecision-1:0]; upper bits read 0.
- 4 STATUS, RO: bit0 busy, bit1 done.
- 5 PIXCNT, RO: count of pixels strobed in the current or last frame.
REQ-018 Writes commit on the clock edge where PSEL=1, PENABLE=1, PWRITE=1.
REQ-019 PRDATA is registered in the setup cycle (PSEL=1, PENABLE=0, PWRITE=0), is valid throughout the access cycle, and is 0 in all other cycles.
REQ-020 Unmapped addresses read 0; writes to them and to RO registers are ignored.
REQ-021 The FSM has two states, IDLE and RUN.
REQ-022 IDLE->RUN occurs on the commit edge of a START write when WIDTH!=0 and HEIGHT!=0; START with a zero dimension is ignored.
REQ-023 START into RUN clears done, clears PIXCNT, and sets pix_col=0 and pix_row=0.
REQ-024 In RUN, pix_en=1 every cycle; after each pixel, pix_col increments; at WIDTH-1, pix_col wraps to 0 and pix_row increments.
REQ-025 The first pix_en is asserted in the cycle after the START commit edge; a frame lasts exactly WIDTH*HEIGHT cycles.
REQ-026 PIXCNT increments on each pix_en cycle, wrapping modulo 2^Amba_Word.
REQ-027 On the pixel (WIDTH-1, HEIGHT-1), frame_done=1 in the following cycle, and the FSM returns to IDLE with done=1.
REQ-028 busy=1 exactly while the FSM is in RUN.
REQ-029 In RUN, writes to WIDTH, HEIGHT and THRESH are ignored and START is ignored.
REQ-030 An ABORT write in RUN returns the FSM to IDLE on the commit edge, with no frame_done and done unchanged at 0.
REQ-031 If START and ABORT are written together, ABORT wins, and the block stays in or returns to IDLE.
REQ-032 In IDLE, pix_en=0, and pix_col and pix_row hold their last values.

Reset
REQ-033 When rst=1 at a clock edge:
- FSM goes to IDLE.
- WIDTH, HEIGHT, THRESH and PIXCNT are cleared to 0.
- done and busy are cleared to 0.
- PRDATA, pix_en, pix_col, pix_row and frame_done are driven to 0.
REQ-034 rst during RUN aborts the frame on that edge with no frame_done; the APB transfer in flight is discarded.

Verification
REQ-035 Write WIDTH=4, HEIGHT=2, THRESH=0x80, then read each back. Required: reads return 4, 2, 0x0080; PRDATA is 0 outside access cycles.
REQ-036 With WIDTH=4, HEIGHT=2, write START. Required:
- pix_en high for exactly 8 cycles, starting the cycle after commit.
- (col,row) sequence (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1).
- frame_done pulses once; STATUS then reads 0x2 and PIXCNT reads 8.
REQ-037 Write START with HEIGHT=0. Required: pix_en stays 0 and STATUS reads 0.
REQ-038 With WIDTH=3, HEIGHT=3, after 4 pixels write WIDTH=9 and then ABORT. Required:
- cfg_width stays 3.
- pix_en drops on the ABORT commit edge.
- No frame_done; STATUS reads 0; PIXCNT reads 5 (the ABORT edge commits during the fifth pix_en cycle).
REQ-039 Assert rst mid-frame. Required: all outputs are 0 on the next cycle and all registers read 0.
REQ-040 Write START and ABORT together (CTRL=0x3). Required: no pixels are strobed.

Source files
------------

// File: rtl/ls_apb_ctrl.sv
// APB-programmed frame sequencer for the line separator: holds image geometry and
// threshold, and walks a raster of pixel strobes once per START command.
module ls_apb_ctrl #(
  parameter int Amba_Addr_Depth = 20,
  parameter int Amba_Word       = 16,
  parameter int PixelPrecision  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [Amba_Addr_Depth-1:0] PADDR,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [Amba_Word-1:0]       PWDATA,
  output logic [Amba_Word-1:0]       PRDATA,
  output logic [Amba_Word-1:0]       cfg_width,
  output logic [Amba_Word-1:0]       cfg_height,
  output logic [PixelPrecision-1:0]  cfg_thresh,
  output logic                       pix_en,
  output logic [Amba_Word-1:0]       pix_col,
  output logic [Amba_Word-1:0]       pix_row,
  output logic                       frame_done
);

  localparam logic [Amba_Addr_Depth-1:0] ADDR_CTRL   = Amba_Addr_Depth'(0);
  localparam logic [Amba_Addr_Depth-1:0] ADDR_WIDTH  = Amba_Addr_Depth'(1);
  localparam logic [Amba_Addr_Depth-1:0] ADDR_HEIGHT = Amba_Addr_Depth'(2);
  localparam logic [Amba_Addr_Depth-1:0] ADDR_THRESH = Amba_Addr_Depth'(3);
  localparam logic [Amba_Addr_Depth-1:0] ADDR_STATUS = Amba_Addr_Depth'(4);
  localparam logic [Amba_Addr_Depth-1:0] ADDR_PIXCNT = Amba_Addr_Depth'(5);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [Amba_Word-1:0]      width;
  logic [Amba_Word-1:0]      height;
  logic [PixelPrecision-1:0] thresh;
  logic [Amba_Word-1:0]      pixcnt;
  logic [Amba_Word-1:0]      col;
  logic [Amba_Word-1:0]      row;
  logic [Amba_Word-1:0]      rd_data;
  logic                      done;
  logic                      busy;
  logic                      wr_commit;
  logic                      rd_setup;
  logic                      start_req;
  logic                      abort_req;
  logic                      dims_ok;
  logic                      col_last;
  logic                      last_pix;
  logic                      go_run;
  logic                      finish;

  assign wr_commit = PSEL & PENABLE & PWRITE;
  assign rd_setup  = PSEL & ~PENABLE & ~PWRITE;
  assign start_req = wr_commit && (PADDR == ADDR_CTRL) && PWDATA[0];
  assign abort_req = wr_commit && (PADDR == ADDR_CTRL) && PWDATA[1];
  assign dims_ok   = (width != '0) && (height != '0);
  assign col_last  = (col == width - Amba_Word'(1));
  assign last_pix  = col_last && (row == height - Amba_Word'(1));
  assign busy      = (state == RUN);
  assign pix_en    = busy;

  assign cfg_width  = width;
  assign cfg_height = height;
  assign cfg_thresh = thresh;
  assign pix_col    = col;
  assign pix_row    = row;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ABORT takes priority over both START and the natural end of frame.
  always_comb begin
    state_nxt = state;
    go_run    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start_req && !abort_req && dims_ok) begin
          state_nxt = RUN;
          go_run    = 1'b1;
        end
      end
      RUN: begin
        if (abort_req) begin
          state_nxt = IDLE;
        end else if (last_pix) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Geometry and threshold are frozen while a frame is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      width  <= '0;
      height <= '0;
      thresh <= '0;
    end else if (wr_commit && (state == IDLE)) begin
      case (PADDR)
        ADDR_WIDTH:  width  <= PWDATA;
        ADDR_HEIGHT: height <= PWDATA;
        ADDR_THRESH: thresh <= PWDATA[PixelPrecision-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      pixcnt     <= '0;
      done       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= finish;
      if (go_run) begin
        col    <= '0;
        row    <= '0;
        pixcnt <= '0;
        done   <= 1'b0;
      end else if (pix_en) begin
        pixcnt <= pixcnt + Amba_Word'(1);
        if (col_last) begin
          col <= '0;
          row <= row + Amba_Word'(1);
        end else begin
          col <= col + Amba_Word'(1);
        end
        if (finish) done <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (PADDR)
      ADDR_WIDTH:  rd_data = width;
      ADDR_HEIGHT: rd_data = height;
      ADDR_THRESH: rd_data = Amba_Word'(thresh);
      ADDR_STATUS: rd_data = Amba_Word'({done, busy});
      ADDR_PIXCNT: rd_data = pixcnt;
      default:     rd_data = '0;
    endcase
  end

  // Read data is captured in the setup phase and is zero outside the access phase.
  always_ff @(posedge clk) begin
    if (rst)           PRDATA <= '0;
    else if (rd_setup) PRDATA <= rd_data;
    else               PRDATA <= '0;
  end

endmodule

// File: tb/tb_ls_apb_ctrl.sv
// Directed self-checking bench for ls_apb_ctrl: register access, full frame,
// ignored START, abort mid-frame, combined START+ABORT and reset mid-frame.
module tb_ls_apb_ctrl;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic [DW-1:0] cfg_width;
  logic [DW-1:0] cfg_height;
  logic [PW-1:0] cfg_thresh;
  logic          pix_en;
  logic [DW-1:0] pix_col;
  logic [DW-1:0] pix_row;
  logic          frame_done;

  int total = 0;
  int bad   = 0;

  ls_apb_ctrl #(
    .Amba_Addr_Depth(AW),
    .Amba_Word(DW),
    .PixelPrecision(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .PADDR(PADDR),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PWRITE(PWRITE),
    .PWDATA(PWDATA),
    .PRDATA(PRDATA),
    .cfg_width(cfg_width),
    .cfg_height(cfg_height),
    .cfg_thresh(cfg_thresh),
    .pix_en(pix_en),
    .pix_col(pix_col),
    .pix_row(pix_row),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Call 1ns after a rising edge; commits on the second following edge.
  task automatic applyStimulus(input int addr, input int data);
    PADDR   = AW'(addr);
    PWDATA  = DW'(data);
    PSEL    = 1'b1;
    PWRITE  = 1'b1;
    PENABLE = 1'b0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(posedge clk); #1;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
  endtask

  task automatic readRegister(input string tag, input int addr, input int exp);
    PADDR   = AW'(addr);
    PSEL    = 1'b1;
    PWRITE  = 1'b0;
    PENABLE = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_setup"}, 32'(PRDATA), 32'h0);
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(negedge clk);
    checkOutput(tag, 32'(PRDATA), 32'(exp));
    @(posedge clk); #1;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    checkOutput({tag, "_after"}, 32'(PRDATA), 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    PADDR   = '0;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PWDATA  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_pix_en", 32'(pix_en), 32'h0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'h0);
    checkOutput("rst_prdata", 32'(PRDATA), 32'h0);
    checkOutput("rst_width", 32'(cfg_width), 32'h0);

    // register write / read-back
    applyStimulus(1, 4);
    applyStimulus(2, 2);
    applyStimulus(3, 'h1FF);
    checkOutput("thresh_trunc_cfg", 32'(cfg_thresh), 32'hFF);
    readRegister("thresh_trunc_rd", 3, 'h00FF);
    applyStimulus(3, 'h80);
    checkOutput("cfg_width", 32'(cfg_width), 32'd4);
    checkOutput("cfg_height", 32'(cfg_height), 32'd2);
    checkOutput("cfg_thresh", 32'(cfg_thresh), 32'h80);
    readRegister("rd_width", 1, 4);
    readRegister("rd_height", 2, 2);
    readRegister("rd_thresh", 3, 'h0080);
    readRegister("rd_ctrl", 0, 0);
    readRegister("rd_unmapped", 7, 0);
    applyStimulus(4, 'h3);
    readRegister("rd_status_ro", 4, 0);

    // START with a zero dimension is ignored
    applyStimulus(2, 0);
    applyStimulus(0, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("zero_h_pix_en%0d", i), 32'(pix_en), 32'h0);
    end
    @(posedge clk); #1;
    readRegister("zero_h_status", 4, 0);
    applyStimulus(2, 2);

    // full 4x2 frame
    applyStimulus(0, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput($sformatf("frm_pix_en%0d", i), 32'(pix_en), 32'h1);
      checkOutput($sformatf("frm_col%0d", i), 32'(pix_col), 32'(i % 4));
      checkOutput($sformatf("frm_row%0d", i), 32'(pix_row), 32'(i / 4));
      checkOutput($sformatf("frm_fd_low%0d", i), 32'(frame_done), 32'h0);
    end
    @(negedge clk);
    checkOutput("frm_done_pulse", 32'(frame_done), 32'h1);
    checkOutput("frm_pix_en_end", 32'(pix_en), 32'h0);
    @(negedge clk);
    checkOutput("frm_done_single", 32'(frame_done), 32'h0);
    @(posedge clk); #1;
    readRegister("frm_status", 4, 'h2);
    readRegister("frm_pixcnt", 5, 8);

    // abort a 3x3 frame during its fifth pixel; WIDTH write in RUN is ignored
    applyStimulus(1, 3);
    applyStimulus(2, 3);
    applyStimulus(0, 1);
    @(posedge clk); #1;
    applyStimulus(1, 9);
    checkOutput("abt_pix_en_before", 32'(pix_en), 32'h1);
    applyStimulus(0, 2);
    checkOutput("abt_pix_en_after", 32'(pix_en), 32'h0);
    checkOutput("abt_cfg_width", 32'(cfg_width), 32'd3);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("abt_no_fd%0d", i), 32'(frame_done), 32'h0);
    end
    @(posedge clk); #1;
    readRegister("abt_status", 4, 0);
    readRegister("abt_pixcnt", 5, 5);

    // START and ABORT together: ABORT wins
    applyStimulus(0, 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("both_pix_en%0d", i), 32'(pix_en), 32'h0);
    end
    @(posedge clk); #1;
    readRegister("both_status", 4, 0);
    readRegister("both_pixcnt", 5, 5);

    // reset in the middle of a frame, with a read setup in flight
    applyStimulus(3, 'h55);
    applyStimulus(0, 1);
    @(posedge clk); #1;
    PADDR  = AW'(5);
    PSEL   = 1'b1;
    PWRITE = 1'b0;
    rst    = 1'b1;
    @(posedge clk); #1;
    rst  = 1'b0;
    PSEL = 1'b0;
    checkOutput("mid_rst_pix_en", 32'(pix_en), 32'h0);
    checkOutput("mid_rst_col", 32'(pix_col), 32'h0);
    checkOutput("mid_rst_row", 32'(pix_row), 32'h0);
    checkOutput("mid_rst_prdata", 32'(PRDATA), 32'h0);
    checkOutput("mid_rst_fd", 32'(frame_done), 32'h0);
    checkOutput("mid_rst_width", 32'(cfg_width), 32'h0);
    checkOutput("mid_rst_height", 32'(cfg_height), 32'h0);
    checkOutput("mid_rst_thresh", 32'(cfg_thresh), 32'h0);
    readRegister("mid_rst_rd_width", 1, 0);
    readRegister("mid_rst_rd_height", 2, 0);
    readRegister("mid_rst_rd_thresh", 3, 0);
    readRegister("mid_rst_rd_status", 4, 0);
    readRegister("mid_rst_rd_pixcnt", 5, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("mid_rst_no_fd%0d", i), 32'(frame_done), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
